des_key_schedule: RTL and testbench

Sequential DES round-key generator; the producer side of the 48-bit round-key input consumed by the Feistel round function. It loads a 64-bit key, applies PC-1, and emits one 48-bit PC-2 round key per accepted handshake. Keys come out K1..K16 for encryption or K16..K1 for decryption, so a single-round iterative datapath can use one key stream in either direction.

---
 rtl/des_pkg.sv | 52 +++++
 rtl/des_pc2.sv | 16 +
 rtl/des_key_schedule.sv | 116 +++++++++++
 tb/tb_des_key_schedule.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, the per-round shift table,
// schedule state encoding, width constants and the half-register rotators.
package des_pkg;

  localparam int KEY_W  = 64;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;
  localparam int RK_W   = 48;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  // Tables use the 1-based bit numbering of the DES standard (bit 1 = MSB).
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < CD_W; i++) begin
      cd[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TBL[i])];
    end
    return cd;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] s);
    return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] s);
    return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: combinational 56-to-48 bit selection of {C,D}.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd_in,
  output logic [RK_W-1:0] rk_out
);

  always_comb begin
    rk_out = '0;
    for (int i = 0; i < RK_W; i++) begin
      rk_out[6'(RK_W - 1 - i)] = cd_in[6'(CD_W - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator emitting K1..K16 (encrypt) or K16..K1 (decrypt).
// Optional key parity checking is built when DES_KS_PARITY_CHECK_EN is defined.
module des_key_schedule
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              decrypt,
  input  logic              key_in_valid,
  output logic              key_in_ready,
  output logic [RK_W-1:0]   round_key,
  output logic [3:0]        rk_round,
  output logic              rk_last,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              done,
  output logic [7:0]        parity_err
);

  ks_state_e         state_q, state_d;
  logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
  logic [3:0]        j_q, j_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic [CD_W-1:0]   pc1_key;
  logic              load, accept;

  assign pc1_key = pc1(key_in);
  assign load    = key_in_valid && (state_q == ST_IDLE);
  assign accept  = (state_q == ST_RUN) && rk_ready;

  // Decrypt starts from C16/D16, which equal C0/D0 since the shifts total 28.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    j_d     = j_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (load) begin
      c_d     = decrypt ? pc1_key[55:28] : rotl28(pc1_key[55:28], SHIFT_TBL[0]);
      d_d     = decrypt ? pc1_key[27:0]  : rotl28(pc1_key[27:0],  SHIFT_TBL[0]);
      j_d     = 4'd0;
      mode_d  = decrypt;
      state_d = ST_RUN;
    end else if (accept) begin
      if (j_q == 4'd15) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        j_d = j_q + 4'd1;
        c_d = mode_q ? rotr28(c_q, SHIFT_TBL[4'd15 - j_q]) : rotl28(c_q, SHIFT_TBL[j_q + 4'd1]);
        d_d = mode_q ? rotr28(d_q, SHIFT_TBL[4'd15 - j_q]) : rotl28(d_q, SHIFT_TBL[j_q + 4'd1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      j_q     <= 4'd0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      j_q     <= j_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

`ifdef DES_KS_PARITY_CHECK_EN
  logic [7:0][7:0] key_bytes;
  logic [7:0]      parity_d, parity_q;

  // Packed byte 7 is key byte 0 (bits 63:56), so flag bit k tracks key_bytes[k].
  assign key_bytes = key_in;

  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = {~^key_bytes[7], ~^key_bytes[6], ~^key_bytes[5], ~^key_bytes[4],
                  ~^key_bytes[3], ~^key_bytes[2], ~^key_bytes[1], ~^key_bytes[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 8'h00;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 8'h00;
`endif

  des_pc2 u_pc2 (
    .cd_in  ({c_q, d_q}),
    .rk_out (round_key)
  );

  assign key_in_ready = (state_q == ST_IDLE);
  assign rk_valid     = (state_q == ST_RUN);
  assign rk_round     = mode_q ? (4'd15 - j_q) : j_q;
  assign rk_last      = (state_q == ST_RUN) && (j_q == 4'd15);
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: bit-level DES key-schedule model plus
// directed streams (encrypt, decrypt, backpressure, mid-stream load, reset abort, parity).
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        key_in_valid = 1'b0;
  logic        key_in_ready;
  logic [47:0] round_key;
  logic [3:0]  rk_round;
  logic        rk_last;
  logic        rk_valid;
  logic        rk_ready = 1'b1;
  logic        done;
  logic [7:0]  parity_err;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_in_valid (key_in_valid),
    .key_in_ready (key_in_ready),
    .round_key    (round_key),
    .rk_round     (rk_round),
    .rk_last      (rk_last),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .done         (done),
    .parity_err   (parity_err)
  );

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KEY_P = 64'h133457799BBCDFF0;

  int PC1_M [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int PC2_M [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH_M [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  int cap_sel = 3;
  logic [47:0] enc_cap [16];
  logic [47:0] dec_cap [16];
  logic [47:0] stl_cap [16];

  // Model state: whether a stream is running, how many keys were accepted, direction, key.
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  bit          m_dec = 1'b0;
  int          m_acc = 0;
  logic [63:0] m_key = '0;
  logic [7:0]  m_parity = '0;

  // Kn straight from the DES definition: cumulative left rotation of the PC-1 halves.
  function automatic logic [47:0] model_key(input logic [63:0] key, input int n);
    int tot;
    bit cd [56];
    bit cr [56];
    logic [47:0] rk;
    tot = 0;
    for (int i = 0; i < n; i++) tot += SH_M[i];
    for (int i = 0; i < 56; i++) cd[i] = key[64 - PC1_M[i]];
    for (int i = 0; i < 28; i++) begin
      cr[i]      = cd[(i + tot) % 28];
      cr[28 + i] = cd[28 + (i + tot) % 28];
    end
    for (int p = 0; p < 48; p++) rk[47 - p] = cr[PC2_M[p] - 1];
    return rk;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_run    <= 1'b0;
      m_done   <= 1'b0;
      m_acc    <= 0;
      m_parity <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (key_in_valid) begin
          m_key <= key_in;
          m_dec <= decrypt;
          m_run <= 1'b1;
          m_acc <= 0;
`ifdef DES_KS_PARITY_CHECK_EN
          for (int b = 0; b < 8; b++) m_parity[7 - b] <= ~^key_in[63 - 8*b -: 8];
`endif
        end
      end else if (rk_ready) begin
        if (m_acc == 15) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_acc <= m_acc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = m_dec ? (16 - m_acc) : (m_acc + 1);
      chk("key_in_ready", key_in_ready, !m_run);
      chk("rk_valid", rk_valid, m_run);
      chk("done", done, m_done);
      chk("parity_err", parity_err, m_parity);
      if (m_run) begin
        chk("rk_round", rk_round, n - 1);
        chk("round_key", round_key, model_key(m_key, n));
        chk("rk_last", rk_last, m_acc == 15);
      end
      if (done) done_cnt++;
      if (rk_valid) begin
        case (cap_sel)
          0: enc_cap[rk_round] = round_key;
          1: dec_cap[rk_round] = round_key;
          2: stl_cap[rk_round] = round_key;
          default: ;
        endcase
      end
    end
  end

  task automatic load(input logic [63:0] k, input bit dec);
    key_in       = k;
    decrypt      = dec;
    key_in_valid = 1'b1;
    rk_ready     = 1'b1;
    step();
    key_in_valid = 1'b0;
    decrypt      = ~dec;
  endtask

  task automatic finish_stream(input string nm, input bit stall);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (m_done) begin
        seen = 1'b1;
        break;
      end
    end
    rk_ready = 1'b1;
    chk({nm, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    int dc0;
    bit ok;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    step();
    chk("rst_ready", key_in_ready, 1'b1);
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_key", round_key, 48'h0);
    chk("rst_round", rk_round, 4'd0);
    chk("rst_last", rk_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_parity", parity_err, 8'h00);
    rst = 1'b0;

    chk("model_k1", model_key(KEY_A, 1), 48'h1B02EFFC7072);
    chk("model_k2", model_key(KEY_A, 2), 48'h79AED9DBC9E5);
    chk("model_k16", model_key(KEY_A, 16), 48'hCB3D8B0E17F5);

    // Encrypt stream, no stalls.
    cap_sel = 0;
    dc0 = done_cnt;
    load(KEY_A, 1'b0);
    chk("enc_first_key", round_key, 48'h1B02EFFC7072);
    chk("enc_first_round", rk_round, 4'd0);
    for (int n = 0; n < 20 && !rk_last; n++) step();
    chk("enc_last_key", round_key, 48'hCB3D8B0E17F5);
    chk("enc_last_flag", rk_last, 1'b1);
    finish_stream("enc", 1'b0);
    chk("enc_done_cycle", done, 1'b1);
    chk("enc_done_ready", key_in_ready, 1'b1);
    step();
    chk("enc_done_once", done_cnt - dc0, 1);
`ifdef DES_KS_PARITY_CHECK_EN
    chk("parity_ok_key", parity_err, 8'h00);
`endif

    // Decrypt stream, no stalls.
    cap_sel = 1;
    load(KEY_A, 1'b1);
    chk("dec_first_key", round_key, 48'hCB3D8B0E17F5);
    chk("dec_first_round", rk_round, 4'd15);
    for (int n = 0; n < 20 && !rk_last; n++) step();
    chk("dec_last_key", round_key, 48'h1B02EFFC7072);
    chk("dec_last_round", rk_round, 4'd0);
    finish_stream("dec", 1'b0);
    step();
    ok = 1'b1;
    for (int r = 0; r < 16; r++) if (dec_cap[r] !== enc_cap[r]) ok = 1'b0;
    chk("dec_is_enc_reversed", ok, 1'b1);

    // Random backpressure.
    cap_sel = 2;
    dc0 = done_cnt;
    load(KEY_A, 1'b0);
    finish_stream("stall", 1'b1);
    step();
    chk("stall_done_once", done_cnt - dc0, 1);
    ok = 1'b1;
    for (int r = 0; r < 16; r++) if (stl_cap[r] !== enc_cap[r]) ok = 1'b0;
    chk("stall_seq_same", ok, 1'b1);

    // Mid-stream load request ignored; held request taken on the done cycle.
    cap_sel = 3;
    load(KEY_A, 1'b0);
    repeat (3) step();
    key_in       = KEY_B;
    decrypt      = 1'b0;
    key_in_valid = 1'b1;
    finish_stream("mid", 1'b0);
    chk("b2b_done_cycle", done, 1'b1);
    step();
    key_in_valid = 1'b0;
    chk("b2b_valid", rk_valid, 1'b1);
    chk("b2b_first_key", round_key, model_key(KEY_B, 1));
    finish_stream("b2b", 1'b0);
    step();

    // Reset abort at j = 7.
    dc0 = done_cnt;
    load(KEY_A, 1'b0);
    for (int n = 0; n < 7; n++) step();
    chk("abort_at_j7", rk_round, 4'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", rk_valid, 1'b0);
    chk("abort_ready", key_in_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    repeat (3) step();
    chk("abort_no_done", done_cnt - dc0, 0);
    load(KEY_A, 1'b0);
    chk("reload_first_key", round_key, 48'h1B02EFFC7072);
    finish_stream("reload", 1'b0);
    step();

    // Parity: last byte F0 has even parity.
    load(KEY_P, 1'b0);
`ifdef DES_KS_PARITY_CHECK_EN
    chk("parity_bad_key", parity_err, 8'h01);
`else
    chk("parity_tied_off", parity_err, 8'h00);
`endif
    finish_stream("par", 1'b0);
    step();
    load(KEY_A, 1'b0);
    chk("parity_good_key", parity_err, 8'h00);
    finish_stream("par2", 1'b0);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
